// File: rtl/ghost_motion_ctrl_if.sv
// Maze wall-map query port: the controller asks about one tile, the maze answers with a one-cycle ack.
interface ghost_motion_ctrl_if;
  logic       wall_req;
  logic [4:0] wall_tx;
  logic [4:0] wall_ty;
  logic       wall_ack;
  logic       wall_hit;

  modport master (output wall_req, wall_tx, wall_ty, input wall_ack, wall_hit);
  modport slave  (input wall_req, wall_tx, wall_ty, output wall_ack, wall_hit);
endinterface

// File: rtl/ghost_motion_ctrl.sv
// Per-frame ghost mover: steps each enabled ghost one pixel and, on tile boundaries,
// probes the wall map and turns toward the free neighbour closest to its target tile.
module ghost_motion_ctrl #(
  parameter int unsigned TILE_W       = 8,
  parameter int unsigned MAZE_W_TILES = 28,
  parameter int unsigned MAZE_H_TILES = 31,
  parameter logic [8:0]  HOME_X       = 9'd96,
  parameter logic [8:0]  HOME_Y       = 9'd112
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [3:0]                 enable,
  input  logic [8:0]                 pac_x,
  input  logic [8:0]                 pac_y,
  ghost_motion_ctrl_if.master        wall,
  output logic [8:0]                 x_red,
  output logic [8:0]                 y_red,
  output logic [8:0]                 x_pink,
  output logic [8:0]                 y_pink,
  output logic [8:0]                 x_blue,
  output logic [8:0]                 y_blue,
  output logic [8:0]                 x_orange,
  output logic [8:0]                 y_orange,
  output logic                       busy
);

  localparam int unsigned POS_W   = 9;
  localparam int unsigned TC_W    = 10;
  localparam int unsigned COST_W  = 7;
  localparam int unsigned TILE_SH = $clog2(TILE_W);
  localparam logic [POS_W-1:0]       X_WRAP  = POS_W'((MAZE_W_TILES - 1) * TILE_W);
  localparam logic [POS_W-1:0]       SUB_MSK = POS_W'(TILE_W - 1);
  localparam logic signed [TC_W-1:0] W_TILES = TC_W'(MAZE_W_TILES);
  localparam logic signed [TC_W-1:0] H_TILES = TC_W'(MAZE_H_TILES);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_PROBE, S_WAIT, S_CHOOSE, S_MOVE, S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       g_q, g_d;
  logic [1:0]       p_q, p_d;
  logic [3:0]       free_q, free_d;
  logic [POS_W-1:0] ptx_q, ptx_d, pty_q, pty_d;
  logic [POS_W-1:0] px_q [4];
  logic [POS_W-1:0] px_d [4];
  logic [POS_W-1:0] py_q [4];
  logic [POS_W-1:0] py_d [4];
  logic [1:0]       dir_q [4];
  logic [1:0]       dir_d [4];
  logic             wall_req_q, wall_req_d;
  logic [4:0]       wall_tx_q, wall_tx_d, wall_ty_q, wall_ty_d;
  logic             busy_q, busy_d;

  logic [POS_W-1:0]       cur_x, cur_y;
  logic [1:0]             cur_dir, rev_dir, best_dir;
  logic                   aligned, found, col_out, row_out;
  logic signed [TC_W-1:0] gtx, gty, pac_tx, pac_ty, ttx, tty, pnx, pny;
  logic signed [TC_W-1:0] nx [4];
  logic signed [TC_W-1:0] ny [4];
  logic [COST_W-1:0]      cost [4];
  logic [COST_W-1:0]      best_cost;
  logic [TC_W-1:0]        orange_dist;
  logic [3:0]             cand;

  function automatic logic [TC_W-1:0] absdiff(input logic signed [TC_W-1:0] a,
                                              input logic signed [TC_W-1:0] b);
    logic signed [TC_W-1:0] diff;
    diff = a - b;
    return (diff < 0) ? TC_W'(-diff) : TC_W'(diff);
  endfunction

  // Current ghost's tile, its target tile, and the four neighbour tiles with their costs
  always_comb begin
    cur_x   = px_q[g_q];
    cur_y   = py_q[g_q];
    cur_dir = dir_q[g_q];
    aligned = ((cur_x & SUB_MSK) == '0) && ((cur_y & SUB_MSK) == '0);
    gtx     = TC_W'(cur_x >> TILE_SH);
    gty     = TC_W'(cur_y >> TILE_SH);
    pac_tx  = TC_W'(ptx_q);
    pac_ty  = TC_W'(pty_q);
    orange_dist = absdiff(gtx, pac_tx) + absdiff(gty, pac_ty);
    ttx = pac_tx;
    tty = pac_ty;
    case (g_q)
      2'd2: begin
        ttx = W_TILES - 10'sd1;
        tty = H_TILES - 10'sd1;
      end
      2'd3: begin
        if (orange_dist <= TC_W'(8)) begin
          ttx = '0;
          tty = H_TILES - 10'sd1;
        end
      end
      default: ;
    endcase
    for (int d = 0; d < 4; d++) begin
      nx[d] = gtx;
      ny[d] = gty;
      case (2'(d))
        DIR_UP:    ny[d] = gty - 10'sd1;
        DIR_LEFT:  nx[d] = gtx - 10'sd1;
        DIR_DOWN:  ny[d] = gty + 10'sd1;
        default:   nx[d] = gtx + 10'sd1;
      endcase
      cost[d] = COST_W'(absdiff(nx[d], ttx) + absdiff(ny[d], tty));
    end
    pnx     = nx[p_q];
    pny     = ny[p_q];
    col_out = (pnx < 10'sd0) || (pnx >= W_TILES);
    row_out = (pny < 10'sd0) || (pny >= H_TILES);
  end

  // Cheapest non-reversing free direction; strict '<' keeps the earlier probe on ties
  always_comb begin
    rev_dir   = cur_dir + 2'd2;
    cand      = free_q & ~(4'b0001 << rev_dir);
    found     = 1'b0;
    best_dir  = rev_dir;
    best_cost = '1;
    for (int d = 0; d < 4; d++) begin
      if (cand[d] && (!found || (cost[d] < best_cost))) begin
        found     = 1'b1;
        best_dir  = 2'(d);
        best_cost = cost[d];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    p_d        = p_q;
    free_d     = free_q;
    ptx_d      = ptx_q;
    pty_d      = pty_q;
    px_d       = px_q;
    py_d       = py_q;
    dir_d      = dir_q;
    wall_req_d = wall_req_q;
    wall_tx_d  = wall_tx_q;
    wall_ty_d  = wall_ty_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          ptx_d   = pac_x >> TILE_SH;
          pty_d   = pac_y >> TILE_SH;
          g_d     = 2'd0;
          busy_d  = 1'b1;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (!enable[g_q]) begin
          state_d = S_NEXT;
        end else if (!aligned) begin
          state_d = S_MOVE;
        end else begin
          free_d  = '0;
          p_d     = 2'd0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        // Off the side is the tunnel (open); off the top or bottom is solid
        if (col_out || row_out) begin
          free_d[p_q] = col_out;
          if (p_q == 2'd3) state_d = S_CHOOSE;
          else             p_d     = p_q + 2'd1;
        end else begin
          wall_req_d = 1'b1;
          wall_tx_d  = 5'(pnx);
          wall_ty_d  = 5'(pny);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wall.wall_ack && wall_req_q) begin
          free_d[p_q] = ~wall.wall_hit;
          wall_req_d  = 1'b0;
          if (p_q == 2'd3) begin
            state_d = S_CHOOSE;
          end else begin
            p_d     = p_q + 2'd1;
            state_d = S_PROBE;
          end
        end
      end
      S_CHOOSE: begin
        if (found) begin
          dir_d[g_q] = best_dir;
          state_d    = S_MOVE;
        end else if (free_q[rev_dir]) begin
          dir_d[g_q] = rev_dir;
          state_d    = S_MOVE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_MOVE: begin
        case (cur_dir)
          DIR_UP:   py_d[g_q] = cur_y - 9'd1;
          DIR_LEFT: px_d[g_q] = (cur_x == '0) ? X_WRAP : cur_x - 9'd1;
          DIR_DOWN: py_d[g_q] = cur_y + 9'd1;
          default:  px_d[g_q] = (cur_x == X_WRAP) ? '0 : cur_x + 9'd1;
        endcase
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (g_q == 2'd3) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          g_d     = g_q + 2'd1;
          state_d = S_SEL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      p_q        <= '0;
      free_q     <= '0;
      ptx_q      <= '0;
      pty_q      <= '0;
      wall_req_q <= 1'b0;
      wall_tx_q  <= '0;
      wall_ty_q  <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        px_q[i]  <= HOME_X + POS_W'(TILE_W * i);
        py_q[i]  <= HOME_Y;
        dir_q[i] <= DIR_LEFT;
      end
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      p_q        <= p_d;
      free_q     <= free_d;
      ptx_q      <= ptx_d;
      pty_q      <= pty_d;
      wall_req_q <= wall_req_d;
      wall_tx_q  <= wall_tx_d;
      wall_ty_q  <= wall_ty_d;
      busy_q     <= busy_d;
      px_q       <= px_d;
      py_q       <= py_d;
      dir_q      <= dir_d;
    end
  end

  assign wall.wall_req = wall_req_q;
  assign wall.wall_tx  = wall_tx_q;
  assign wall.wall_ty  = wall_ty_q;
  assign busy          = busy_q;
  assign x_red         = px_q[0];
  assign y_red         = py_q[0];
  assign x_pink        = px_q[1];
  assign y_pink        = py_q[1];
  assign x_blue        = px_q[2];
  assign y_blue        = py_q[2];
  assign x_orange      = px_q[3];
  assign y_orange      = py_q[3];

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Scoreboard bench for ghost_motion_ctrl: a tile-level reference model predicts wall queries and
// end-of-pass positions; a maze responder and a pass monitor check them independently of the stimulus.
module tb_ghost_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] enable = 4'b0000;
  logic [8:0] pac_x = '0, pac_y = '0;
  logic [8:0] x_red, y_red, x_pink, y_pink, x_blue, y_blue, x_orange, y_orange;
  logic       busy;

  ghost_motion_ctrl_if mif ();

  ghost_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .pac_x(pac_x), .pac_y(pac_y), .wall(mif),
    .x_red(x_red), .y_red(y_red), .x_pink(x_pink), .y_pink(y_pink),
    .x_blue(x_blue), .y_blue(y_blue), .x_orange(x_orange), .y_orange(y_orange),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state and maze
  int mx[4], my[4], md[4];
  bit wall_m [0:30][0:27];
  int exp_qx[$], exp_qy[$];
  logic [71:0] pos_q[$];
  int ack_delay = 0;
  bit spurious = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      mx[g] = 96 + 8 * g;
      my[g] = 112;
      md[g] = 1;
    end
    exp_qx.delete();
    exp_qy.delete();
    pos_q.delete();
  endtask

  task automatic clear_walls();
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++) wall_m[r][c] = 1'b0;
  endtask

  // One update pass: direction index 0=up 1=left 2=down 3=right
  task automatic model_pass(input logic [3:0] en, input int ptx, input int pty);
    logic [71:0] p;
    for (int g = 0; g < 4; g++) begin
      int tx, ty, ttx, tty, best, bc, rev, c;
      int nx[4], ny[4];
      bit fr[4];
      if (en[g]) begin
        best = md[g];
        if ((mx[g] % 8) == 0 && (my[g] % 8) == 0) begin
          tx = mx[g] / 8;
          ty = my[g] / 8;
          if (g < 2) begin ttx = ptx; tty = pty; end
          else if (g == 2) begin ttx = 27; tty = 30; end
          else if (iabs(tx - ptx) + iabs(ty - pty) > 8) begin ttx = ptx; tty = pty; end
          else begin ttx = 0; tty = 30; end
          for (int d = 0; d < 4; d++) begin
            nx[d] = tx + ((d == 1) ? -1 : (d == 3) ? 1 : 0);
            ny[d] = ty + ((d == 0) ? -1 : (d == 2) ? 1 : 0);
            if (nx[d] < 0 || nx[d] >= 28) fr[d] = 1'b1;
            else if (ny[d] < 0 || ny[d] >= 31) fr[d] = 1'b0;
            else begin
              exp_qx.push_back(nx[d]);
              exp_qy.push_back(ny[d]);
              fr[d] = !wall_m[ny[d]][nx[d]];
            end
          end
          rev = (md[g] + 2) % 4;
          best = -1;
          bc = 0;
          for (int d = 0; d < 4; d++) begin
            if (fr[d] && d != rev) begin
              c = (iabs(nx[d] - ttx) + iabs(ny[d] - tty)) % 128;
              if (best < 0 || c < bc) begin best = d; bc = c; end
            end
          end
          if (best < 0 && fr[rev]) best = rev;
          if (best >= 0) md[g] = best;
        end
        if (best >= 0) begin
          case (md[g])
            0: my[g] = (my[g] + 511) % 512;
            1: mx[g] = (mx[g] == 0) ? 216 : mx[g] - 1;
            2: my[g] = (my[g] + 1) % 512;
            default: mx[g] = (mx[g] == 216) ? 0 : mx[g] + 1;
          endcase
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      p[g*18 +: 9]     = 9'(mx[g]);
      p[g*18 + 9 +: 9] = 9'(my[g]);
    end
    pos_q.push_back(p);
  endtask

  task automatic start_tick(input logic [3:0] en, input logic [8:0] px, input logic [8:0] py);
    @(negedge clk);
    enable = en;
    pac_x = px;
    pac_y = py;
    frame_tick = 1'b1;
    model_pass(en, int'(px >> 3), int'(py >> 3));
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 1;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout actual=busy expected=idle within 3000 cycles");
    end
  endtask

  task automatic run_pass(input logic [3:0] en, input logic [8:0] px, input logic [8:0] py,
                          output int cyc);
    start_tick(en, px, py);
    wait_idle(cyc);
  endtask

  task automatic check_home(input string tag);
    chk({tag, "_x_red"}, int'(x_red), 96);
    chk({tag, "_x_pink"}, int'(x_pink), 104);
    chk({tag, "_x_blue"}, int'(x_blue), 112);
    chk({tag, "_x_orange"}, int'(x_orange), 120);
    chk({tag, "_y_all"}, int'(y_red & y_pink & y_blue & y_orange), 112);
    chk({tag, "_y_any"}, int'(y_red | y_pink | y_blue | y_orange), 112);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_wall_req"}, int'(mif.wall_req), 0);
    chk({tag, "_wall_txy"}, int'({mif.wall_tx, mif.wall_ty}), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_home(tag);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Maze responder: checks each query against the model's expected order and holds ack back by ack_delay
  initial begin
    int cnt, rtx, rty;
    bit pending;
    pending = 1'b0;
    cnt = 0; rtx = 0; rty = 0;
    mif.wall_ack = 1'b0;
    mif.wall_hit = 1'b0;
    forever begin
      @(negedge clk);
      mif.wall_ack = 1'b0;
      if (!rst) begin
        pending = 1'b0;
      end else if (mif.wall_req) begin
        if (!pending) begin
          pending = 1'b1;
          cnt = 0;
          rtx = int'(mif.wall_tx);
          rty = int'(mif.wall_ty);
          if (exp_qx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_query actual=(%0d,%0d) expected=none", rtx, rty);
          end else begin
            chk("query_tx", rtx, exp_qx.pop_front());
            chk("query_ty", rty, exp_qy.pop_front());
          end
        end else begin
          chk("query_tx_hold", int'(mif.wall_tx), rtx);
          chk("query_ty_hold", int'(mif.wall_ty), rty);
        end
        if (cnt >= ack_delay) begin
          mif.wall_ack = 1'b1;
          mif.wall_hit = (rtx < 28 && rty < 31) ? wall_m[rty][rtx] : 1'b1;
          pending = 1'b0;
        end else begin
          cnt++;
        end
      end else if (spurious && $urandom_range(7) == 0) begin
        mif.wall_ack = 1'b1;
        mif.wall_hit = 1'($urandom_range(1));
      end
    end
  end

  // Pass monitor: on every completed pass compare all positions against the scoreboard
  initial begin
    bit prev;
    logic [71:0] e;
    logic [8:0] ax[4], ay[4];
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (prev && !busy) begin
          ax = '{x_red, x_pink, x_blue, x_orange};
          ay = '{y_red, y_pink, y_blue, y_orange};
          if (pos_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pass actual=pass_end expected=no_pass");
          end else begin
            e = pos_q.pop_front();
            for (int g = 0; g < 4; g++) begin
              chk($sformatf("pass_x_g%0d", g), int'(ax[g]), int'(e[g*18 +: 9]));
              chk($sformatf("pass_y_g%0d", g), int'(ay[g]), int'(e[g*18 + 9 +: 9]));
            end
          end
          chk("queries_consumed", exp_qx.size(), 0);
        end
        prev = busy;
      end
    end
  end

  initial begin
    int cyc, bcount;
    logic [8:0] hx[4];
    clear_walls();
    model_reset();
    repeat (2) @(negedge clk);
    check_home("por");
    rst = 1'b1;

    // Reset in the middle of a pass abandons it
    ack_delay = 5;
    start_tick(4'b1111, 9'd40, 9'd40);
    repeat (3) @(negedge clk);
    apply_reset("midpass");
    repeat (10) @(negedge clk);
    chk("midpass_no_resume_busy", int'(busy), 0);
    chk("midpass_no_resume_x_red", int'(x_red), 96);

    // Walled on three sides: forced reversal, then fully boxed in
    ack_delay = 0;
    wall_m[13][12] = 1'b1; wall_m[14][11] = 1'b1; wall_m[15][12] = 1'b1;
    run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("reverse_x_red", int'(x_red), 97);
    for (int i = 0; i < 7; i++) run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("reverse_run_x_red", int'(x_red), 104);
    wall_m[13][13] = 1'b1; wall_m[14][12] = 1'b1; wall_m[15][13] = 1'b1; wall_m[14][14] = 1'b1;
    run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("boxed_x_red", int'(x_red), 104);
    chk("boxed_y_red", int'(y_red), 112);

    // Open maze: four probes, red heads left toward pac
    apply_reset("rst2");
    clear_walls();
    run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("open_x_red", int'(x_red), 95);
    run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("unaligned_x_red", int'(x_red), 94);
    chk("unaligned_pass_le_12", int'(cyc <= 12), 1);

    // Corridor with walls above and below: walk to x=0, then through the tunnel
    for (int c = 0; c < 28; c++) begin
      wall_m[13][c] = 1'b1;
      wall_m[15][c] = 1'b1;
    end
    for (int i = 0; i < 94; i++) run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("corridor_x_red", int'(x_red), 0);
    run_pass(4'b0001, 9'd8, 9'd112, cyc);
    chk("tunnel_x_red", int'(x_red), 216);
    chk("tunnel_y_red", int'(y_red), 112);

    // Slow maze with an extra tick while busy
    apply_reset("rst3");
    clear_walls();
    ack_delay = 5;
    hx = '{9'd96, 9'd104, 9'd112, 9'd120};
    start_tick(4'b1111, 9'd200, 9'd200);
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle(cyc);
    bcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bcount++;
    end
    chk("ignored_tick_busy_cycles", bcount, 0);
    chk("one_step_red", iabs(int'(x_red) - int'(hx[0])) + iabs(int'(y_red) - 112), 1);
    chk("one_step_pink", iabs(int'(x_pink) - int'(hx[1])) + iabs(int'(y_pink) - 112), 1);
    chk("one_step_blue", iabs(int'(x_blue) - int'(hx[2])) + iabs(int'(y_blue) - 112), 1);
    chk("one_step_orange", iabs(int'(x_orange) - int'(hx[3])) + iabs(int'(y_orange) - 112), 1);

    // Randomised passes: random walls, enables, pac, ack delays and stray acks
    spurious = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < 31; r++)
        for (int c = 0; c < 28; c++) wall_m[r][c] = ($urandom_range(3) == 0);
      ack_delay = $urandom_range(3);
      run_pass(4'($urandom_range(15)), 9'($urandom_range(223)), 9'($urandom_range(247)), cyc);
    end
    spurious = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", pos_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
